// File: rtl/bip_prog_loader_pkg.sv
// Shared definitions for the BIP program loader: sync byte, sizes, FSM states, frame helpers.
package bip_prog_loader_pkg;

  localparam int NB_BITS       = 16;
  localparam int NB_BYTE       = 8;
  localparam int INS_MEM_DEPTH = 2048;
  localparam int NB_ADDR       = $clog2(INS_MEM_DEPTH);
  // One extra bit so a full-depth length (2048) fits in the length and word counters
  localparam int NB_LEN        = NB_ADDR + 1;

  localparam logic [NB_BYTE-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CKSUM   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_e;

  function automatic logic [NB_BYTE-1:0] cksum_step(input logic [NB_BYTE-1:0] acc,
                                                    input logic [NB_BYTE-1:0] b);
    return acc ^ b;
  endfunction

  function automatic logic len_ok(input logic [2*NB_BYTE-1:0] len);
    return (len != 16'd0) && (len <= 16'(INS_MEM_DEPTH));
  endfunction

endpackage

// File: rtl/bip_prog_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// master = UART RX / memory side, slave = the loader itself.
interface bip_prog_loader_if;
  import bip_prog_loader_pkg::*;

  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_valid;
  logic               o_mem_wr_en;
  logic [NB_ADDR-1:0] o_mem_addr;
  logic [NB_BITS-1:0] o_mem_wr_data;

  modport master (
    output i_rx_data, i_rx_valid,
    input  o_mem_wr_en, o_mem_addr, o_mem_wr_data
  );

  modport slave (
    input  i_rx_data, i_rx_valid,
    output o_mem_wr_en, o_mem_addr, o_mem_wr_data
  );

endinterface

// File: rtl/bip_loader_timeout.sv
// Inter-byte idle timer: reloads on clear or while disabled, counts down while enabled,
// and pulses expire_o on the TIMEOUT_CYC-th consecutive idle enabled cycle.
module bip_loader_timeout #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int NB_CNT = $clog2(TIMEOUT_CYC + 1);

  logic [NB_CNT-1:0] cnt_q;
  logic [NB_CNT-1:0] cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (clr_i || !en_i) begin
      cnt_d = NB_CNT'(TIMEOUT_CYC);
    end else if (cnt_q == NB_CNT'(1)) begin
      expire_o = 1'b1;
      cnt_d    = NB_CNT'(TIMEOUT_CYC);
    end else begin
      cnt_d = cnt_q - NB_CNT'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= NB_CNT'(TIMEOUT_CYC);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bip_prog_loader.sv
// BIP program loader: parses SYNC/LEN/words frames from a byte stream, writes instruction memory
// from address 0 and releases the CPU reset on success. BIP_LOADER_CKSUM_EN adds a trailing XOR byte.
module bip_prog_loader
  import bip_prog_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  bip_prog_loader_if.slave   bus,
  output logic               o_cpu_rst,
  output logic               o_done,
  output logic               o_err
);

  state_e             state_q, state_d;
  logic [NB_BYTE-1:0] hi_q, hi_d;
  logic [NB_LEN-1:0]  len_q, len_d;
  logic [NB_LEN-1:0]  word_idx_q, word_idx_d;
  logic [NB_BYTE-1:0] cksum_q, cksum_d;
  logic               wr_en_q, wr_en_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [NB_BITS-1:0] wr_data_q, wr_data_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic                 rx_s;
  logic [NB_BYTE-1:0]   byte_s;
  logic [2*NB_BYTE-1:0] len_full_s;
  logic                 to_en_s;
  logic                 to_expire_s;

  assign rx_s       = bus.i_rx_valid;
  assign byte_s     = bus.i_rx_data;
  assign len_full_s = {hi_q, byte_s};
  assign to_en_s    = state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CKSUM};

  bip_loader_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .clr_i    (rx_s),
    .en_i     (to_en_s),
    .expire_o (to_expire_s)
  );

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    cksum_d    = cksum_q;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      // Resting states: only a sync byte starts a (re)load, which re-asserts the CPU reset
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (rx_s && (byte_s == SYNC_BYTE)) begin
          state_d    = ST_LEN_HI;
          cpu_rst_d  = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          word_idx_d = '0;
          addr_d     = '0;
          cksum_d    = 8'h00;
        end else begin
          state_d = state_q;
        end
      end

      ST_LEN_HI: begin
        if (rx_s) begin
          hi_d    = byte_s;
          cksum_d = cksum_step(cksum_q, byte_s);
          state_d = ST_LEN_LO;
        end else if (to_expire_s) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end

      ST_LEN_LO: begin
        if (rx_s) begin
          cksum_d = cksum_step(cksum_q, byte_s);
          if (len_ok(len_full_s)) begin
            len_d   = len_full_s[NB_LEN-1:0];
            state_d = ST_DATA_HI;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end else if (to_expire_s) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end

      ST_DATA_HI: begin
        if (rx_s) begin
          hi_d    = byte_s;
          cksum_d = cksum_step(cksum_q, byte_s);
          state_d = ST_DATA_LO;
        end else if (to_expire_s) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end

      // The low byte completes a word: write it next cycle, and on the last word finish in that same cycle
      ST_DATA_LO: begin
        if (rx_s) begin
          cksum_d    = cksum_step(cksum_q, byte_s);
          wr_en_d    = 1'b1;
          addr_d     = word_idx_q[NB_ADDR-1:0];
          wr_data_d  = {hi_q, byte_s};
          word_idx_d = word_idx_q + NB_LEN'(1);
          if (word_idx_q == (len_q - NB_LEN'(1))) begin
`ifdef BIP_LOADER_CKSUM_EN
            state_d = ST_CKSUM;
`else
            state_d   = ST_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
`endif
          end else begin
            state_d = ST_DATA_HI;
          end
        end else if (to_expire_s) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end

`ifdef BIP_LOADER_CKSUM_EN
      ST_CKSUM: begin
        if (rx_s) begin
          if (byte_s == cksum_q) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end else if (to_expire_s) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
`endif

      default: begin
        state_d   = ST_ERR;
        err_d     = 1'b1;
        done_d    = 1'b0;
        cpu_rst_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      hi_q       <= 8'h00;
      len_q      <= '0;
      word_idx_q <= '0;
      cksum_q    <= 8'h00;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= 16'h0000;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      cksum_q    <= cksum_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_mem_wr_en   = wr_en_q;
  assign bus.o_mem_addr    = addr_q;
  assign bus.o_mem_wr_data = wr_data_q;
  assign o_cpu_rst         = cpu_rst_q;
  assign o_done            = done_q;
  assign o_err             = err_q;

endmodule

// File: tb/tb_bip_prog_loader.sv
// Scoreboard bench for bip_prog_loader: a frame-level model predicts memory writes and final status.
module tb_bip_prog_loader;
  import bip_prog_loader_pkg::*;

  localparam int TO = 64;
`ifdef BIP_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic [NB_ADDR-1:0] addr;
    logic [15:0]        data;
    logic               done;
    logic               cpu_rst;
  } wr_t;

  logic clk;
  logic rst_n;
  logic cpu_rst, done, err;

  bip_prog_loader_if bus_if();

  bip_prog_loader #(.TIMEOUT_CYC(TO)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus_if),
    .o_cpu_rst (cpu_rst),
    .o_done    (done),
    .o_err     (err)
  );

  wr_t exp_q[$];
  wr_t mon_w;
  int  n_cmp = 0;
  int  n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Frame-level reference: expected writes go to the scoreboard, final status is returned
  // status: 0 no frame, 1 loaded, 2 aborted; incomplete: abort comes from the idle timeout
  function automatic void model(input bq_t f, output int status, output bit incomplete);
    int p, len, base;
    logic [7:0] x;
    wr_t w;
    status = 0;
    incomplete = 1'b0;
    p = 0;
    while (p < f.size() && f[p] != 8'hA5) p++;
    if (p >= f.size()) return;
    if (f.size() - p < 3) begin status = 2; incomplete = 1'b1; return; end
    len = int'(f[p+1]) * 256 + int'(f[p+2]);
    if (len == 0 || len > 2048) begin status = 2; return; end
    x = f[p+1] ^ f[p+2];
    for (int i = 0; i < len; i++) begin
      base = p + 3 + 2 * i;
      if (base + 1 >= f.size()) begin status = 2; incomplete = 1'b1; return; end
      x = x ^ f[base] ^ f[base+1];
      w.addr    = NB_ADDR'(i);
      w.data    = {f[base], f[base+1]};
      w.done    = (i == len - 1) && !CK;
      w.cpu_rst = !w.done;
      exp_q.push_back(w);
    end
    if (!CK) begin status = 1; return; end
    base = p + 3 + 2 * len;
    if (base >= f.size()) begin status = 2; incomplete = 1'b1; return; end
    status = (f[base] == x) ? 1 : 2;
  endfunction

  function automatic bq_t with_ck(input bq_t f);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < f.size(); i++) x = x ^ f[i];
    if (CK) f.push_back(x);
    return f;
  endfunction

  function automatic bq_t build_frame(input int len, input bit bad_ck);
    bq_t f;
    f.push_back(8'hA5);
    f.push_back(8'(len >> 8));
    f.push_back(8'(len));
    if (len >= 1 && len <= 2048) begin
      for (int i = 0; i < 2 * len; i++) f.push_back(8'($urandom));
      f = with_ck(f);
      if (bad_ck && CK) f[f.size()-1] = f[f.size()-1] ^ 8'($urandom_range(255, 1));
    end
    return f;
  endfunction

  task automatic send_bytes(input bq_t q, input int max_gap);
    int g;
    foreach (q[i]) begin
      @(negedge clk);
      bus_if.i_rx_data  = q[i];
      bus_if.i_rx_valid = 1'b1;
      g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      repeat (g) begin
        @(negedge clk);
        bus_if.i_rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus_if.i_rx_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input bq_t f, input int max_gap, input bit window);
    int st;
    bit inc;
    model(f, st, inc);
    send_bytes(f, max_gap);
    if (inc) begin
      if (window) begin
        repeat (TO - 4) @(negedge clk);
        chk({name, "_err_early"}, err, 1'b0);
        repeat (12) @(negedge clk);
      end else begin
        repeat (TO + 8) @(negedge clk);
      end
    end else begin
      repeat (4) @(negedge clk);
    end
    chk({name, "_writes_pending"}, exp_q.size(), 0);
    exp_q.delete();
    if (st != 0) begin
      chk({name, "_done"}, done, (st == 1) ? 1 : 0);
      chk({name, "_err"}, err, (st == 2) ? 1 : 0);
      chk({name, "_cpu_rst"}, cpu_rst, (st == 1) ? 0 : 1);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_wr_en"}, bus_if.o_mem_wr_en, 1'b0);
    chk({name, "_addr"}, bus_if.o_mem_addr, 0);
    chk({name, "_wr_data"}, bus_if.o_mem_wr_data, 0);
    chk({name, "_cpu_rst"}, cpu_rst, 1'b1);
    chk({name, "_done"}, done, 1'b0);
    chk({name, "_err"}, err, 1'b0);
  endtask

  // Monitor: every write strobe is matched against the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus_if.o_mem_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: actual addr=%0h data=%0h required no write",
                 bus_if.o_mem_addr, bus_if.o_mem_wr_data);
      end else begin
        mon_w = exp_q.pop_front();
        chk("wr_addr", bus_if.o_mem_addr, mon_w.addr);
        chk("wr_data", bus_if.o_mem_wr_data, mon_w.data);
        chk("wr_done", done, mon_w.done);
        chk("wr_cpu_rst", cpu_rst, mon_w.cpu_rst);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t f, g;
    int  st, kind, d;
    bit  inc;

    bus_if.i_rx_data  = 8'h00;
    bus_if.i_rx_valid = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    run_frame("basic", with_ck({8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}), 0, 1'b0);
    run_frame("len_zero", {8'hA5, 8'h00, 8'h00}, 1, 1'b0);
    run_frame("after_len_zero", build_frame(3, 1'b0), 2, 1'b0);
    run_frame("len_2049", {8'hA5, 8'h08, 8'h01}, 0, 1'b0);
    run_frame("timeout", {8'hA5, 8'h00, 8'h03, 8'h11, 8'h22}, 0, 1'b1);

`ifdef BIP_LOADER_CKSUM_EN
    run_frame("ck_good", {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h27}, 0, 1'b0);
    run_frame("ck_bad", {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h00}, 0, 1'b0);
`endif

    for (int k = 0; k < 10; k++) begin
      kind = $urandom_range(CK ? 4 : 3, 0);
      case (kind)
        0: begin
          f = build_frame($urandom_range(24, 1), 1'b0);
          f.push_front(8'h5A);
        end
        1: f = {8'hA5, 8'h00, 8'h00};
        2: f = build_frame($urandom_range(65535, 2049), 1'b0);
        3: begin
          f = build_frame($urandom_range(24, 1), 1'b0);
          d = $urandom_range(f.size() - 4, 1);
          repeat (d) void'(f.pop_back());
        end
        default: f = build_frame($urandom_range(24, 1), 1'b1);
      endcase
      run_frame("rand", f, $urandom_range(3, 0), 1'b0);
    end

    f = {8'h00, 8'hFF, 8'h5A};
    g = build_frame(2048, 1'b0);
    foreach (g[i]) f.push_back(g[i]);
    run_frame("full_depth", f, 0, 1'b0);
    chk("full_depth_last_addr", bus_if.o_mem_addr, 2047);

    f = {8'hA5, 8'h00, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78};
    model(f, st, inc);
    send_bytes(f, 0);
    repeat (2) @(negedge clk);
    chk("pre_reset_pending", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("after_reset", with_ck({8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF}), 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
